// File: rtl/game_state_decoder_pkg.sv
// Shared encodings for the game state decoder: phase codes, packed field positions,
// screen constants and the BCD digit adjust helper.
package game_state_decoder_pkg;

    typedef enum logic [1:0] {
        PhIdle = 2'b00,
        PhPlay = 2'b01,
        PhOver = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        BcdIdle  = 2'b00,
        BcdLoad  = 2'b01,
        BcdShift = 2'b10
    } bcd_state_e;

    localparam logic [1:0] StatusPlaying = 2'b00;

    localparam int unsigned PipeGapMsb = 27;
    localparam int unsigned PipeGapLsb = 20;
    localparam int unsigned PipeXMsb   = 19;
    localparam int unsigned PipeXLsb   = 10;
    localparam int unsigned PipeYMsb   = 9;
    localparam int unsigned PipeYLsb   = 0;

    localparam int unsigned CoinVisBit = 31;
    localparam int unsigned CoinYMsb   = 19;
    localparam int unsigned CoinYLsb   = 10;
    localparam int unsigned CoinXMsb   = 9;
    localparam int unsigned CoinXLsb   = 0;

    localparam int unsigned BirdRiseBit = 15;
    localparam int unsigned BirdYMsb    = 9;

    localparam logic [9:0] ScreenW  = 10'd640;
    localparam logic [9:0] RespawnX = 10'd640;

    // Shift-add-3 pre-shift correction applied to all five BCD digits.
    function automatic logic [19:0] bcd_add3(input logic [19:0] d);
        logic [19:0] r;
        r = d;
        for (int i = 0; i < 5; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_state_decoder_bcd_serial16.sv
// Serial 16-bit binary to 5-digit BCD converter (shift-add-3, one bit per tick).
module bcd_serial16
    import game_state_decoder_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [19:0] bcd,
    output logic        busy
);

    bcd_state_e  state_q, state_d;
    logic [15:0] last_q, last_d;
    logic [35:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic [35:0] shifted;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        shifted = {bcd_add3(sr_q[35:16]), sr_q[15:0]} << 1;
        unique case (state_q)
            BcdIdle: begin
                // last_q tracks the value being or last converted, so a change mid-run
                // is picked up once the converter returns here.
                if (value != last_q) begin
                    last_d  = value;
                    state_d = BcdLoad;
                end
            end
            BcdLoad: begin
                sr_d    = {20'd0, last_q};
                cnt_d   = 4'd0;
                state_d = BcdShift;
            end
            BcdShift: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_d   = shifted[35:16];
                    state_d = BcdIdle;
                end
            end
            default: state_d = BcdIdle;
        endcase
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_q <= BcdIdle;
            last_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = (state_q != BcdIdle);

endmodule

// File: rtl/game_state_decoder.sv
// Unpacks game controller words one tick late, derives per-tick event pulses,
// tracks the game phase and best score, and feeds the score to a BCD converter.
module game_state_decoder
    import game_state_decoder_pkg::*;
(
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic [1:0]  status,
    input  logic [15:0] score,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    input  logic        clr_best,
    output logic [9:0]  bird_h,
    output logic        bird_rising,
    output logic [29:0] pipe_x,
    output logic [29:0] pipe_y,
    output logic [23:0] pipe_gap,
    output logic [9:0]  coin_x,
    output logic [9:0]  coin_y,
    output logic        coin_vis,
    output logic [2:0]  respawn,
    output logic        coin_taken,
    output logic        flap,
    output logic        score_inc,
    output logic        game_over,
    output logic [1:0]  phase,
    output logic [15:0] best_score,
    output logic [19:0] score_bcd,
    output logic        bcd_busy
);

    logic [2:0][31:0] pipe_w;
    logic [2:0][9:0]  px_new, py_new;
    logic [2:0][7:0]  pg_new;

    logic [9:0]       bird_h_q;
    logic             bird_rising_q;
    logic [2:0][9:0]  pipe_x_q, pipe_y_q;
    logic [2:0][7:0]  pipe_gap_q;
    logic [9:0]       coin_x_q, coin_y_q;
    logic             coin_vis_q;
    logic [15:0]      score_q;
    logic             primed_q;
    logic             still_q, still_d;
    phase_e           phase_q, phase_d;

    logic [2:0]       respawn_q, respawn_d;
    logic             coin_taken_q, coin_taken_d;
    logic             flap_q, flap_d;
    logic             score_inc_q, score_inc_d;
    logic             game_over_q, game_over_d;
    logic             frozen, load_best;
    logic [15:0]      best_q = '0;

    logic             unused_bits;
    assign unused_bits = ^{pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20], bird_y[14:10]};

    assign pipe_w = {pipe3, pipe2, pipe1};

    always_comb begin
        px_new = '0;
        py_new = '0;
        pg_new = '0;
        for (int i = 0; i < 3; i++) begin
            px_new[i] = pipe_w[i][PipeXMsb:PipeXLsb];
            py_new[i] = pipe_w[i][PipeYMsb:PipeYLsb];
            pg_new[i] = pipe_w[i][PipeGapMsb:PipeGapLsb];
        end
    end

    // Events compare this tick's inputs with the registered copies; primed_q masks
    // the first tick after reset, when those copies are still being loaded.
    always_comb begin
        respawn_d = '0;
        for (int i = 0; i < 3; i++) begin
            respawn_d[i] = primed_q && (px_new[i] > pipe_x_q[i]);
        end
        coin_taken_d = primed_q && coin_vis_q && !coin[CoinVisBit];
        flap_d       = primed_q && !bird_rising_q && bird_y[BirdRiseBit];
        score_inc_d  = primed_q && (score > score_q);
        frozen       = primed_q && (px_new == pipe_x_q);
    end

    always_comb begin
        phase_d     = phase_q;
        still_d     = 1'b0;
        game_over_d = 1'b0;
        load_best   = 1'b0;
        unique case (phase_q)
            PhIdle: begin
                if (status == StatusPlaying) phase_d = PhPlay;
            end
            PhPlay: begin
                if (status != StatusPlaying) begin
                    phase_d = PhIdle;
                end else if (frozen) begin
                    if (still_q) begin
                        phase_d     = PhOver;
                        game_over_d = 1'b1;
                        load_best   = 1'b1;
                    end else begin
                        still_d = 1'b1;
                    end
                end
            end
            PhOver: begin
                if (status != StatusPlaying) phase_d = PhIdle;
            end
            default: phase_d = PhIdle;
        endcase
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            bird_h_q      <= '0;
            bird_rising_q <= 1'b0;
            pipe_x_q      <= '0;
            pipe_y_q      <= '0;
            pipe_gap_q    <= '0;
            coin_x_q      <= '0;
            coin_y_q      <= '0;
            coin_vis_q    <= 1'b0;
            score_q       <= '0;
            primed_q      <= 1'b0;
            still_q       <= 1'b0;
            phase_q       <= PhIdle;
            respawn_q     <= '0;
            coin_taken_q  <= 1'b0;
            flap_q        <= 1'b0;
            score_inc_q   <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            bird_h_q      <= bird_y[BirdYMsb:0];
            bird_rising_q <= bird_y[BirdRiseBit];
            pipe_x_q      <= px_new;
            pipe_y_q      <= py_new;
            pipe_gap_q    <= pg_new;
            coin_x_q      <= coin[CoinXMsb:CoinXLsb];
            coin_y_q      <= coin[CoinYMsb:CoinYLsb];
            coin_vis_q    <= coin[CoinVisBit];
            score_q       <= score;
            primed_q      <= 1'b1;
            still_q       <= still_d;
            phase_q       <= phase_d;
            respawn_q     <= respawn_d;
            coin_taken_q  <= coin_taken_d;
            flap_q        <= flap_d;
            score_inc_q   <= score_inc_d;
            game_over_q   <= game_over_d;
        end
    end

    // Best score survives rst; only clr_best clears it, and it wins over a game-over load.
    always_ff @(posedge clk_100ms) begin
        if (clr_best) begin
            best_q <= '0;
        end else if (load_best && (score > best_q)) begin
            best_q <= score;
        end
    end

    bcd_serial16 u_bcd (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .value     (score_q),
        .bcd       (score_bcd),
        .busy      (bcd_busy)
    );

    assign bird_h      = bird_h_q;
    assign bird_rising = bird_rising_q;
    assign pipe_x      = pipe_x_q;
    assign pipe_y      = pipe_y_q;
    assign pipe_gap    = pipe_gap_q;
    assign coin_x      = coin_x_q;
    assign coin_y      = coin_y_q;
    assign coin_vis    = coin_vis_q;
    assign respawn     = respawn_q;
    assign coin_taken  = coin_taken_q;
    assign flap        = flap_q;
    assign score_inc   = score_inc_q;
    assign game_over   = game_over_q;
    assign phase       = phase_q;
    assign best_score  = best_q;

endmodule

// File: tb/tb_game_state_decoder.sv
// Directed bench for game_state_decoder: unpacking, event pulses, phase FSM,
// best score handling and serial BCD timing.
module tb_game_state_decoder;

    logic        clk_100ms = 1'b0;
    logic        rst;
    logic [1:0]  status;
    logic [15:0] score;
    logic [15:0] bird_y;
    logic [31:0] pipe1, pipe2, pipe3, coin;
    logic        clr_best;
    logic [9:0]  bird_h;
    logic        bird_rising;
    logic [29:0] pipe_x, pipe_y;
    logic [23:0] pipe_gap;
    logic [9:0]  coin_x, coin_y;
    logic        coin_vis;
    logic [2:0]  respawn;
    logic        coin_taken, flap, score_inc, game_over;
    logic [1:0]  phase;
    logic [15:0] best_score;
    logic [19:0] score_bcd;
    logic        bcd_busy;

    logic [9:0]  p1x, p2x, p3x;
    logic        cvis;
    logic        move;
    logic [6:0]  ev;
    int          n_pass = 0;
    int          n_total = 0;

    assign pipe1 = {4'hF, 8'd40, p1x, 10'd100};
    assign pipe2 = {4'h5, 8'd50, p2x, 10'd200};
    assign pipe3 = {4'hA, 8'd60, p3x, 10'd300};
    assign coin  = {cvis, 11'h2AA, 10'd77, 10'd33};
    assign ev    = {respawn, coin_taken, flap, score_inc, game_over};

    always #5 clk_100ms = ~clk_100ms;

    game_state_decoder dut (
        .clk_100ms   (clk_100ms),
        .rst         (rst),
        .status      (status),
        .score       (score),
        .bird_y      (bird_y),
        .pipe1       (pipe1),
        .pipe2       (pipe2),
        .pipe3       (pipe3),
        .coin        (coin),
        .clr_best    (clr_best),
        .bird_h      (bird_h),
        .bird_rising (bird_rising),
        .pipe_x      (pipe_x),
        .pipe_y      (pipe_y),
        .pipe_gap    (pipe_gap),
        .coin_x      (coin_x),
        .coin_y      (coin_y),
        .coin_vis    (coin_vis),
        .respawn     (respawn),
        .coin_taken  (coin_taken),
        .flap        (flap),
        .score_inc   (score_inc),
        .game_over   (game_over),
        .phase       (phase),
        .best_score  (best_score),
        .score_bcd   (score_bcd),
        .bcd_busy    (bcd_busy)
    );

    task automatic tick();
        if (move) p1x = p1x - 10'd1;
        @(posedge clk_100ms);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One round: restart, play a few moving ticks, then freeze the pipes until game over.
    task automatic play_round(input logic [15:0] s, input logic clr, input logic [15:0] exp_best);
        status = 2'b01;
        tick();
        chk("round_idle", 32'(phase), 32'd0);
        status = 2'b00;
        move   = 1'b1;
        score  = s;
        tick();
        chk("round_play", 32'(phase), 32'd1);
        tick();
        move = 1'b0;
        tick();
        clr_best = clr;
        tick();
        clr_best = 1'b0;
        chk("round_over_phase", 32'(phase), 32'd2);
        chk("round_over_pulse", 32'(ev), 32'h01);
        chk("round_best", 32'(best_score), 32'(exp_best));
    endtask

    initial begin
        rst      = 1'b0;
        clr_best = 1'b1;
        status   = 2'b01;
        score    = 16'd0;
        bird_y   = 16'h0000;
        p1x      = 10'd210;
        p2x      = 10'd400;
        p3x      = 10'd500;
        cvis     = 1'b1;
        move     = 1'b0;

        tick();
        tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_pipe_x", 32'(pipe_x), 32'd0);
        chk("rst_events", 32'(ev), 32'd0);
        chk("rst_bcd", 32'(score_bcd), 32'd0);
        chk("rst_busy", 32'(bcd_busy), 32'd0);
        chk("rst_coin_vis", 32'(coin_vis), 32'd0);
        chk("clr_best_init", 32'(best_score), 32'd0);

        // First tick after release: inputs that would all fire events stay silent.
        rst      = 1'b1;
        clr_best = 1'b0;
        status   = 2'b00;
        score    = 16'd3;
        bird_y   = {1'b1, 5'h1F, 10'd123};
        tick();
        chk("t1_phase", 32'(phase), 32'd1);
        chk("t1_events", 32'(ev), 32'd0);
        chk("t1_pipe1_x", 32'(pipe_x[9:0]), 32'd210);
        chk("t1_bird_h", 32'(bird_h), 32'd123);
        chk("t1_bird_rising", 32'(bird_rising), 32'd1);
        p1x = 10'd208;
        tick();
        chk("t2_events", 32'(ev), 32'd0);
        p1x = 10'd206;
        tick();
        chk("t3_pipe_x", 32'(pipe_x), 32'({10'd500, 10'd400, 10'd206}));
        chk("t3_pipe_y", 32'(pipe_y), 32'({10'd300, 10'd200, 10'd100}));
        chk("t3_pipe_gap", 32'(pipe_gap), 32'({8'd60, 8'd50, 8'd40}));
        chk("t3_coin", 32'({coin_vis, coin_y, coin_x}), 32'({1'b1, 10'd77, 10'd33}));
        chk("t3_events", 32'(ev), 32'd0);
        chk("t3_phase", 32'(phase), 32'd1);

        move = 1'b1;
        p2x  = 10'd2;
        tick();
        chk("p2_low_events", 32'(ev), 32'd0);
        p2x = 10'd640;
        tick();
        chk("p2_respawn", 32'(ev), 32'h20);
        chk("p2_x_640", 32'(pipe_x[19:10]), 32'd640);
        tick();
        chk("p2_respawn_end", 32'(ev), 32'd0);

        bird_y[15] = 1'b0;
        tick();
        chk("fall_events", 32'(ev), 32'd0);
        bird_y[15] = 1'b1;
        tick();
        chk("flap", 32'(ev), 32'h04);

        score = 16'd7;
        tick();
        chk("score_inc_3_7", 32'(ev), 32'h02);
        repeat (40) tick();
        chk("bcd_7", 32'(score_bcd), 32'h00007);
        chk("bcd_7_idle", 32'(bcd_busy), 32'd0);

        cvis  = 1'b0;
        score = 16'd9;
        tick();
        chk("coin_and_inc", 32'(ev), 32'h0A);
        repeat (17) tick();
        chk("bcd_9_pending", 32'(score_bcd), 32'h00007);
        chk("bcd_9_busy", 32'(bcd_busy), 32'd1);
        tick();
        chk("bcd_9", 32'(score_bcd), 32'h00009);
        chk("bcd_9_idle", 32'(bcd_busy), 32'd0);

        score = 16'd10;
        tick();
        chk("score_inc_plus1", 32'(ev), 32'h02);

        // Pipes freeze while the score drops: no score_inc, game over on the 2nd frozen tick.
        move  = 1'b0;
        score = 16'd5;
        tick();
        chk("drop_events", 32'(ev), 32'd0);
        chk("frozen1_phase", 32'(phase), 32'd1);
        tick();
        chk("over_pulse", 32'(ev), 32'h01);
        chk("over_phase", 32'(phase), 32'd2);
        chk("best_5", 32'(best_score), 32'd5);
        tick();
        chk("over_pulse_end", 32'(ev), 32'd0);
        chk("over_hold", 32'(phase), 32'd2);

        play_round(16'd12, 1'b0, 16'd12);
        play_round(16'd12, 1'b1, 16'd0);
        play_round(16'd12, 1'b0, 16'd12);
        play_round(16'd8, 1'b0, 16'd12);

        repeat (40) tick();
        score = 16'd65535;
        tick();
        chk("max_busy_before", 32'(bcd_busy), 32'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("max_busy_run", 32'(bcd_busy), 32'd1);
        end
        tick();
        chk("max_busy_done", 32'(bcd_busy), 32'd0);
        chk("max_bcd", 32'(score_bcd), 32'h65535);

        score = 16'd1234;
        tick();
        repeat (5) tick();
        chk("mid_conv_busy", 32'(bcd_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(score_bcd), 32'd0);
        chk("async_rst_busy", 32'(bcd_busy), 32'd0);
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_pipe_x", 32'(pipe_x), 32'd0);
        chk("async_rst_best", 32'(best_score), 32'd12);
        tick();
        chk("rst_hold_best", 32'(best_score), 32'd12);
        rst = 1'b1;
        tick();
        repeat (18) tick();
        chk("post_rst_bcd", 32'(score_bcd), 32'h01234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
